// File: rtl/interval_pkg.sv
// Shared class codes, channel FSM states and the gap classification rule
// used by the interval classifier.
package interval_pkg;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'b00,
    CLS_FAST   = 2'b01,
    CLS_NORMAL = 2'b10,
    CLS_SLOW   = 2'b11
  } class_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } ch_state_t;

  // Maps a non-zero gap (below the timeout) to its class code.
  function automatic class_t classify_gap(input int gap, input int fast_max,
                                          input int normal_max);
    class_t c;
    if (gap <= fast_max) begin
      c = CLS_FAST;
    end else if (gap <= normal_max) begin
      c = CLS_NORMAL;
    end else begin
      c = CLS_SLOW;
    end
    return c;
  endfunction

endpackage

// File: rtl/interval_channel.sv
// One channel: measures the run of zeros between 1s on x and publishes a
// class code with a one-cycle valid pulse; long gaps end in a timeout.
module interval_channel
  import interval_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int FAST_MAX   = 1,
  parameter int NORMAL_MAX = 2,
  parameter int TIMEOUT    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       x,
  output logic [1:0] y,
  output logic       y_valid,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] GAP_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] GAP_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(TIMEOUT - 1);

  ch_state_t        state_r, state_s;
  logic [CNT_W-1:0] gap_r, gap_s;
  class_t           y_r, y_s;
  logic             valid_r, valid_s;
  logic             timeout_r, timeout_s;

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      gap_r     <= GAP_ZERO;
      y_r       <= CLS_NONE;
      valid_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      gap_r     <= gap_s;
      y_r       <= y_s;
      valid_r   <= valid_s;
      timeout_r <= timeout_s;
    end
  end

  // Next-state and output decode; the counter is cleared on reaching
  // TIMEOUT-1 plus a zero, so it can never wrap.
  always_comb begin
    state_s   = state_r;
    gap_s     = gap_r;
    y_s       = y_r;
    valid_s   = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (x) begin
          state_s = ST_ARMED;
          gap_s   = GAP_ZERO;
        end else begin
          gap_s   = GAP_ZERO;
        end
      end
      ST_ARMED: begin
        if (x) begin
          if (gap_r != GAP_ZERO) begin
            y_s     = classify_gap(int'(gap_r), FAST_MAX, NORMAL_MAX);
            valid_s = 1'b1;
          end else begin
            valid_s = 1'b0;
          end
          gap_s = GAP_ZERO;
        end else if (gap_r == GAP_LAST) begin
          y_s       = CLS_SLOW;
          valid_s   = 1'b1;
          timeout_s = 1'b1;
          state_s   = ST_IDLE;
          gap_s     = GAP_ZERO;
        end else begin
          gap_s = gap_r + GAP_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        gap_s   = GAP_ZERO;
      end
    endcase
  end

  assign y       = y_r;
  assign y_valid = valid_r;
  assign timeout = timeout_r;

endmodule

// File: rtl/interval_classifier.sv
// Multi-channel interval classifier: parameter checks plus one
// interval_channel per input bit, packed onto the output buses.
module interval_classifier
  import interval_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int CNT_W      = 4,
  parameter int FAST_MAX   = 1,
  parameter int NORMAL_MAX = 2,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   x,
  output logic [2*CHANNELS-1:0] y,
  output logic [CHANNELS-1:0]   y_valid,
  output logic [CHANNELS-1:0]   timeout
);

  if (!((FAST_MAX >= 1) && (FAST_MAX < NORMAL_MAX) && (NORMAL_MAX < TIMEOUT) &&
        (TIMEOUT <= (1 << CNT_W) - 1))) begin : g_bad_params
    $error("interval_classifier: illegal FAST_MAX/NORMAL_MAX/TIMEOUT/CNT_W");
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    interval_channel #(
      .CNT_W     (CNT_W),
      .FAST_MAX  (FAST_MAX),
      .NORMAL_MAX(NORMAL_MAX),
      .TIMEOUT   (TIMEOUT)
    ) u_channel (
      .clk    (clk),
      .rst    (rst),
      .x      (x[k]),
      .y      (y[2*k +: 2]),
      .y_valid(y_valid[k]),
      .timeout(timeout[k])
    );
  end

endmodule
